// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT frame streamer.
//   - default sample width and frame length
//   - transaction state type
//   - clog2 constant function used to size counters
package fft_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned SEQ_LENGTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV
  } state_t;

  // Smallest n with 2**n >= value.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: complex sample buffer (separate real and imaginary arrays)
// with one write port and one registered read port.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset (read register only)
//   we, waddr         write enable and index
//   wreal, wimg       write data
//   re, raddr         read enable and index
//   rreal, rimg       registered read data, one cycle after raddr
// A read and write to the same index in one cycle returns the new data.
module fft_frame_buf #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wreal,
  input  logic [DATA_WIDTH-1:0] wimg,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rreal,
  output logic [DATA_WIDTH-1:0] rimg
);

  logic [DATA_WIDTH-1:0] mem_real [DEPTH];
  logic [DATA_WIDTH-1:0] mem_img  [DEPTH];

  // Storage has no reset so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_real[waddr] <= wreal;
      mem_img[waddr]  <= wimg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rreal <= '0;
      rimg  <= '0;
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rreal <= wreal;
        rimg  <= wimg;
      end else begin
        rreal <= mem_real[raddr];
        rimg  <= mem_img[raddr];
      end
    end
  end

endmodule

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: frame-level partner for the 16-point FFT.
// Holds one input frame loaded by the host, streams it into the FFT on
// start, then collects the FFT result frame into a host-readable buffer.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   load_we/addr/real/img        host write into the input frame (IDLE only)
//   start                        begin a transaction (IDLE only)
//   tx_real/tx_img/tx_valid      sample stream to FFT input
//   rx_real/rx_img/rx_valid      result stream from FFT output
//   rx_done                      FFT end-of-frame
//   rd_addr, rd_real/rd_img      host read of result frame, 1-cycle latency
//   busy                         not IDLE
//   frame_done                   1-cycle pulse on a complete, clean frame
//   err_timeout, err_frame       sticky errors, cleared by accepted start
module fft_frame_streamer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned SEQ_LENGTH = SEQ_LENGTH_DEF,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_real,
  input  logic [DATA_WIDTH-1:0] load_img,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] tx_real,
  output logic [DATA_WIDTH-1:0] tx_img,
  output logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] rx_real,
  input  logic [DATA_WIDTH-1:0] rx_img,
  input  logic                  rx_valid,
  input  logic                  rx_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_real,
  output logic [DATA_WIDTH-1:0] rd_img,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic                  err_frame
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned WAIT_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_TX  = CNT_W'(SEQ_LENGTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SEQ_LENGTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  state_t state, state_next;

  logic [CNT_W-1:0]      tx_cnt, tx_cnt_next;
  logic [CNT_W-1:0]      rx_cnt, rx_cnt_next, rx_cnt_upd;
  logic [WAIT_W-1:0]     wait_cnt, wait_cnt_next;
  logic                  tx_valid_next;
  logic                  frame_done_next;
  logic                  err_timeout_next;
  logic                  err_frame_next;
  logic                  long_beat;
  logic                  res_we;
  logic [ADDR_WIDTH-1:0] res_waddr;
  logic                  in_we;
  logic                  in_re;

  assign busy  = (state != ST_IDLE);
  assign in_we = load_we && (state == ST_IDLE);
  assign in_re = (state == ST_SEND);

  fft_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (SEQ_LENGTH)
  ) u_in_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (in_we),
    .waddr   (load_addr),
    .wreal   (load_real),
    .wimg    (load_img),
    .re      (in_re),
    .raddr   (tx_cnt[ADDR_WIDTH-1:0]),
    .rreal   (tx_real),
    .rimg    (tx_img)
  );

  fft_frame_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (SEQ_LENGTH)
  ) u_res_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (res_we),
    .waddr   (res_waddr),
    .wreal   (rx_real),
    .wimg    (rx_img),
    .re      (1'b1),
    .raddr   (rd_addr),
    .rreal   (rd_real),
    .rimg    (rd_img)
  );

  // tx data comes from the buffer's registered read port, so tx_valid is
  // registered from the SEND state to stay aligned with it. The final beat
  // therefore appears during the first WAIT cycle.
  always_comb begin
    state_next       = state;
    tx_cnt_next      = tx_cnt;
    rx_cnt_next      = rx_cnt;
    rx_cnt_upd       = rx_cnt;
    wait_cnt_next    = wait_cnt;
    tx_valid_next    = (state == ST_SEND);
    frame_done_next  = 1'b0;
    err_timeout_next = err_timeout;
    err_frame_next   = err_frame;
    long_beat        = 1'b0;
    res_we           = 1'b0;
    res_waddr        = rx_cnt[ADDR_WIDTH-1:0];

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next       = ST_SEND;
          tx_cnt_next      = '0;
          rx_cnt_next      = '0;
          wait_cnt_next    = '0;
          err_timeout_next = 1'b0;
          err_frame_next   = 1'b0;
        end
      end

      ST_SEND: begin
        tx_cnt_next = tx_cnt + 1'b1;
        if (tx_cnt == LAST_TX) begin
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (rx_valid) begin
          res_we      = 1'b1;
          res_waddr   = '0;
          rx_cnt_next = CNT_W'(1);
          state_next  = ST_RECV;
        end else if (wait_cnt == WAIT_MAX) begin
          err_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      ST_RECV: begin
        // Capture first; the done check below sees the updated count.
        // The count stops at a full frame; extra beats only flag an error.
        if (rx_valid) begin
          if (rx_cnt < FULL_CNT) begin
            res_we     = 1'b1;
            rx_cnt_upd = rx_cnt + 1'b1;
          end else begin
            long_beat = 1'b1;
          end
        end
        rx_cnt_next = rx_cnt_upd;
        if (long_beat) begin
          err_frame_next = 1'b1;
        end
        if (rx_done) begin
          state_next = ST_IDLE;
          if ((rx_cnt_upd == FULL_CNT) && !err_frame && !long_beat) begin
            frame_done_next = 1'b1;
          end else begin
            err_frame_next = 1'b1;
          end
        end else if (!rx_valid && (rx_cnt < FULL_CNT)) begin
          err_frame_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      wait_cnt    <= '0;
      tx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      state       <= state_next;
      tx_cnt      <= tx_cnt_next;
      rx_cnt      <= rx_cnt_next;
      wait_cnt    <= wait_cnt_next;
      tx_valid    <= tx_valid_next;
      frame_done  <= frame_done_next;
      err_timeout <= err_timeout_next;
      err_frame   <= err_frame_next;
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Bench for fft_frame_streamer: table of response scenarios, random frame
// data, and hand sequences for timeout, mid-transaction reset and
// busy-time load/start.
module tb_fft_frame_streamer;

  localparam int N  = 16;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [15:0] load_real, load_img;
  logic        start;
  logic [15:0] tx_real, tx_img;
  logic        tx_valid;
  logic [15:0] rx_real, rx_img;
  logic        rx_valid, rx_done;
  logic [3:0]  rd_addr;
  logic [15:0] rd_real, rd_img;
  logic        busy, frame_done, err_timeout, err_frame;

  fft_frame_streamer #(
    .DATA_WIDTH (16),
    .SEQ_LENGTH (16),
    .ADDR_WIDTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_real   (load_real),
    .load_img    (load_img),
    .start       (start),
    .tx_real     (tx_real),
    .tx_img      (tx_img),
    .tx_valid    (tx_valid),
    .rx_real     (rx_real),
    .rx_img      (rx_img),
    .rx_valid    (rx_valid),
    .rx_done     (rx_done),
    .rd_addr     (rd_addr),
    .rd_real     (rd_real),
    .rd_img      (rd_img),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int beats;      // rx_valid beats the responder sends
    int gap;        // idle cycles after the tx stream
    int done_mode;  // 0: no rx_done, 1: rx_done after last beat, 2: with last beat
    bit exp_done;
    bit exp_ferr;
  } vec_t;

  vec_t tbl[7];

  // Reference contents of both buffers.
  logic [15:0] in_re[N], in_im[N];
  logic [15:0] res_re[N], res_im[N];

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_seen++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load_frame(input bit ramp);
    for (int k = 0; k < N; k++) begin
      in_re[k]  = ramp ? 16'(k + 1)    : 16'($urandom);
      in_im[k]  = ramp ? 16'(-(k + 1)) : 16'($urandom);
      load_we   = 1'b1;
      load_addr = 4'(k);
      load_real = in_re[k];
      load_img  = in_im[k];
      tick();
    end
    load_we = 1'b0;
  endtask

  task automatic start_and_check_tx;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("errs_cleared", {err_timeout, err_frame}, 0);
    n = 0;
    while (!tx_valid && n < 8) begin
      tick();
      n++;
    end
    check("tx_latency", n, 1);
    for (int k = 0; k < N; k++) begin
      check("tx_valid", tx_valid, 1);
      check("tx_real", tx_real, in_re[k]);
      check("tx_img", tx_img, in_im[k]);
      check("tx_busy", busy, 1);
      tick();
    end
    check("tx_end", tx_valid, 0);
  endtask

  task automatic read_all;
    for (int a = 0; a < N; a++) begin
      rd_addr = 4'(a);
      tick();
      check("rd_real", rd_real, res_re[a]);
      check("rd_img", rd_img, res_im[a]);
    end
  endtask

  task automatic respond(input vec_t v, input bit ramp);
    int d0;
    int n;
    d0 = done_seen;
    repeat (v.gap) tick();
    for (int k = 0; k < v.beats; k++) begin
      rx_valid = 1'b1;
      rx_real  = ramp ? 16'(16'h0100 + k) : 16'($urandom);
      rx_img   = 16'($urandom);
      rx_done  = (v.done_mode == 2) && (k == v.beats - 1);
      if (k < N) begin
        res_re[k] = rx_real;
        res_im[k] = rx_img;
        rd_addr   = 4'(k);
      end
      tick();
      if (k < N) check("rd_bypass", rd_real, res_re[k]);
    end
    rx_valid = 1'b0;
    rx_done  = (v.done_mode == 1);
    tick();
    rx_done = 1'b0;
    n = 0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    check("idle_after_rx", busy, 0);
    tick();
    tick();
    check("frame_done_count", done_seen - d0, v.exp_done ? 1 : 0);
    check("err_frame", err_frame, v.exp_ferr);
    check("err_timeout_rx", err_timeout, 0);
    read_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    vec_t ok16;

    tbl[0] = '{16, 20, 1, 1'b1, 1'b0};
    tbl[1] = '{16,  3, 2, 1'b1, 1'b0};
    tbl[2] = '{15,  5, 1, 1'b0, 1'b1};
    tbl[3] = '{17,  0, 1, 1'b0, 1'b1};
    tbl[4] = '{10,  7, 0, 1'b0, 1'b1};
    tbl[5] = '{16,  1, 1, 1'b1, 1'b0};
    tbl[6] = '{15,  2, 2, 1'b0, 1'b1};
    ok16   = '{16,  2, 1, 1'b1, 1'b0};

    reset_n = 1'b0; load_we = 1'b0; load_addr = '0; load_real = '0; load_img = '0;
    start = 1'b0; rx_real = '0; rx_img = '0; rx_valid = 1'b0; rx_done = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_errs", {err_timeout, err_frame}, 0);
    check("rst_rd_real", rd_real, 0);
    check("rst_tx_real", tx_real, 0);
    reset_n = 1'b1;
    tick();

    // Table scenarios; first entry uses the ramp frame and 0x0100+k results.
    for (int i = 0; i < 7; i++) begin
      load_frame(i == 0);
      start_and_check_tx();
      respond(tbl[i], i == 0);
      if (i == 0) begin
        rd_addr = 4'd5;
        tick();
        check("rd5_real", rd_real, 16'h0105);
      end
    end

    // No response: timeout.
    load_frame(1'b0);
    d0 = done_seen;
    start_and_check_tx();
    n = 0;
    while (!err_timeout && n < 400) begin
      tick();
      n++;
    end
    check("timeout_flag", err_timeout, 1);
    check("timeout_window", (n >= TO - 4) && (n <= TO + 4), 1);
    check("timeout_idle", busy, 0);
    check("timeout_err_frame", err_frame, 0);
    tick();
    check("timeout_no_done", done_seen - d0, 0);
    start_and_check_tx();
    respond(ok16, 1'b0);

    // Reset during the 8th SEND beat.
    d0 = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (7) tick();
    check("beat8_real", tx_real, in_re[7]);
    reset_n = 1'b0;
    tick();
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tx_real", tx_real, 0);
    reset_n = 1'b1;
    tick();
    check("rst_mid_no_done", done_seen - d0, 0);
    start_and_check_tx();
    respond(ok16, 1'b0);

    // load_we and start while busy are ignored.
    start_and_check_tx();
    load_we   = 1'b1;
    load_addr = 4'd0;
    load_real = ~in_re[0];
    load_img  = ~in_im[0];
    start     = 1'b1;
    tick();
    load_we = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("busy_start_no_tx", tx_valid, 0);
      tick();
    end
    respond(ok16, 1'b0);
    start_and_check_tx();
    respond(ok16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Frame-level partner for the 16-point FFT top block.
- Holds one input frame in a local buffer, loaded by a host write port.
- On `start`, transmits the frame as a back-to-back sample stream into the FFT's `valid_in` interface.
- Then receives the FFT's `valid_out`/`done` result stream into a result buffer, readable by the host, with timeout and framing-error detection.

Parameters:
- DATA_WIDTH, 16, bits per real/imaginary sample
- SEQ_LENGTH, 16, samples per frame (power of two)
- ADDR_WIDTH, 4, log2(SEQ_LENGTH)
- TIMEOUT, 255, max cycles in WAIT for the first rx_valid before error

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- load_we  in  1  write one input sample into the frame buffer
- load_addr  in  ADDR_WIDTH  input buffer index
- load_real  in  DATA_WIDTH  real part to load
- load_img  in  DATA_WIDTH  imaginary part to load
- start  in  1  begin a transaction (accepted in IDLE only)
- tx_real  out  DATA_WIDTH  sample to FFT data_in_real
- tx_img  out  DATA_WIDTH  sample to FFT data_in_img
- tx_valid  out  1  drives FFT valid_in
- rx_real  in  DATA_WIDTH  FFT data_out_real
- rx_img  in  DATA_WIDTH  FFT data_out_img
- rx_valid  in  1  FFT valid_out
- rx_done  in  1  FFT done
- rd_addr  in  ADDR_WIDTH  result buffer read index
- rd_real  out  DATA_WIDTH  result real, 1-cycle registered read
- rd_img  out  DATA_WIDTH  result imaginary, 1-cycle registered read
- busy  out  1  high in any state except IDLE
- frame_done  out  1  1-cycle pulse on successful completion
- err_timeout  out  1  sticky; cleared by next accepted start
- err_frame  out  1  sticky; short or long result frame; cleared by next accepted start

Behaviour:
- Reset is synchronous (reset_n low at a clk edge). All outputs go to 0 and state goes to IDLE. Buffers are not cleared. Reset mid-transaction aborts immediately with no frame_done.
- Load port: active only in IDLE; load_we is ignored while busy. start and load_we in the same IDLE cycle: the write completes, then SEND begins.
- States:
  - IDLE -> SEND on start. tx_cnt=0, rx_cnt=0, errors cleared, wait_cnt=0.
  - SEND: tx_valid=1; tx_real/img = in_buf[tx_cnt], registered; tx_cnt++. Exactly SEQ_LENGTH consecutive valid beats, no bubbles, because the FFT captures every READ cycle. After the last beat: tx_valid=0, go to WAIT.
  - WAIT: wait_cnt++ each cycle. On rx_valid: capture beat 0, rx_cnt=1, go to RECV. If wait_cnt reaches TIMEOUT: err_timeout=1, go to IDLE.
  - RECV: each rx_valid cycle, res_buf[rx_cnt] <= rx data, rx_cnt++.
    - Beats beyond SEQ_LENGTH: not written, err_frame=1.
    - rx_valid low before SEQ_LENGTH beats, or rx_done before SEQ_LENGTH beats: err_frame=1, go to IDLE.
    - rx_done with rx_cnt==SEQ_LENGTH and no error: frame_done pulses for 1 cycle, go to IDLE.
    - rx_valid and rx_done in the same cycle: the beat is captured first, then the done check uses the updated count.
- Counters: tx_cnt and rx_cnt are ADDR_WIDTH+1 bits, so they never wrap within a frame. wait_cnt is sized to hold TIMEOUT.
- Result read: rd_real/rd_img = res_buf[rd_addr], registered one cycle later. Legal at any time; a read during RECV returns the old or new value per write-before-read ordering (new data wins at the same address).
- start while busy: ignored.

Decomposition:
- Shared package `fft_pkg`:
  - DATA_WIDTH/SEQ_LENGTH defaults
  - state encoding localparams (IDLE, SEND, WAIT, RECV)
  - a clog2 constant function
- One natural sub-module: `fft_frame_buf`, a dual-array sample buffer with 1 write port and 1 registered read port. Instantiate it twice, for the input frame and the result frame.

Test Plan:
- Load in_buf[k]=k+1 (real) and -(k+1) (img), then start. Expect tx_valid high exactly 16 consecutive cycles carrying 0x0001..0x0010 and 0xFFFF..0xFFF0 in order. Expect busy=1 and no gaps.
- Loopback responder: 20 cycles after the last tx, drive 16 rx_valid beats with rx_real=0x0100+k, then rx_done. Expect frame_done to pulse once. Reading rd_addr=5 must give rd_real=0x0105 on the next cycle.
- No response: expect err_timeout=1 after TIMEOUT cycles in WAIT, then IDLE, busy=0, frame_done never asserted. A subsequent start clears err_timeout.
- Responder sends 15 beats then rx_done: expect err_frame=1 and no frame_done. Responder sends 17 beats: expect res_buf[0..15] intact and err_frame=1.
- Assert reset_n=0 at the 8th SEND beat: on the next edge expect tx_valid=0, busy=0, IDLE. A new start restarts at sample 0.
- Pulse load_we and start while busy: no change to in_buf and no restart; transaction completes normally.
